// File: rtl/hex_disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_disp_pkg: shared types and constants for the hex digit display.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hex_disp_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {
        STEP_UP   = 1'b0,
        STEP_DOWN = 1'b1
    } step_dir_t;

    // Returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_digit_sequencer_button_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_debounce: synchronise a raw button, accept a level after it   |
// | has been stable, and pulse once on each accepted press.  Rev 1.0     |
// +----------------------------------------------------------------------+
module button_debounce
    import hex_disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk50MHz,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int                CNT_W  = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end
        end
    end

    assign btn_level = r_level;
    assign btn_press = r_press;

endmodule
`default_nettype wire

// File: rtl/hex_digit_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_digit_sequencer: prescaled up/down hex counter with load and     |
// | debounced run/pause and direction buttons.  Rev 1.0                  |
// +----------------------------------------------------------------------+
module hex_digit_sequencer
    import hex_disp_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int STEP_HZ         = 2,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic               clk50MHz,
    input  logic               rst,
    input  logic               btn_run,
    input  logic               btn_dir,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_value,
    output logic [DIGIT_W-1:0] HEX_out,
    output logic               dp_out,
    output logic               tick,
    output logic               wrap
);

    localparam int                 DIV        = CLK_HZ / STEP_HZ;
    localparam int                 PRE_W      = clog2(DIV);
    localparam logic [PRE_W-1:0]   C_PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0]   C_PRE_ONE  = PRE_W'(1);
    localparam logic [DIGIT_W-1:0] C_HEX_ONE  = DIGIT_W'(1);
    localparam logic [DIGIT_W-1:0] C_HEX_MAX  = {DIGIT_W{1'b1}};

    logic [PRE_W-1:0]   r_pre;
    logic [DIGIT_W-1:0] r_hex;
    logic               r_paused;
    step_dir_t          r_dir;
    logic               r_tick;
    logic               r_wrap;

    logic               w_run_press;
    logic               w_dir_press;
    logic               w_unused_run_level;
    logic               w_unused_dir_level;
    logic               w_step;
    logic               w_at_wrap;
    logic [DIGIT_W-1:0] w_hex_step;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_btn (
        .clk50MHz (clk50MHz),
        .rst      (rst),
        .btn_raw  (btn_run),
        .btn_level(w_unused_run_level),
        .btn_press(w_run_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dir_btn (
        .clk50MHz (clk50MHz),
        .rst      (rst),
        .btn_raw  (btn_dir),
        .btn_level(w_unused_dir_level),
        .btn_press(w_dir_press)
    );

    always_comb begin
        w_step     = 1'b0;
        w_at_wrap  = 1'b0;
        w_hex_step = r_hex;
        w_step     = !r_paused && (r_pre == C_PRE_LAST);
        if (r_dir == STEP_UP) begin
            w_hex_step = r_hex + C_HEX_ONE;
            w_at_wrap  = (r_hex == C_HEX_MAX);
        end else begin
            w_hex_step = r_hex - C_HEX_ONE;
            w_at_wrap  = (r_hex == '0);
        end
    end

    // Button toggles land on the same edge as a step, so that step still
    // uses the old direction and a pause press lets it complete.
    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            r_pre    <= '0;
            r_hex    <= '0;
            r_paused <= 1'b0;
            r_dir    <= STEP_UP;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (load) begin
                r_hex <= load_value;
                r_pre <= '0;
            end else if (w_step) begin
                r_hex  <= w_hex_step;
                r_tick <= 1'b1;
                r_wrap <= w_at_wrap;
                r_pre  <= '0;
            end else if (r_paused) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + C_PRE_ONE;
            end
            if (w_run_press) begin
                r_paused <= !r_paused;
            end
            if (w_dir_press) begin
                r_dir <= (r_dir == STEP_UP) ? STEP_DOWN : STEP_UP;
            end
        end
    end

    assign HEX_out = r_hex;
    assign dp_out  = r_paused;
    assign tick    = r_tick;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_hex_digit_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hex_digit_sequencer: directed vectors for hex_digit_sequencer     |
// | with DIV=10 and DEBOUNCE_CYCLES=4.  Rev 1.0                          |
// +----------------------------------------------------------------------+
module tb_hex_digit_sequencer;

    logic       clk50MHz = 1'b0;
    logic       rst;
    logic       btn_run;
    logic       btn_dir;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] HEX_out;
    logic       dp_out;
    logic       tick;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         wait_cyc;
        logic       do_load;
        logic [3:0] ld_val;
        logic [3:0] exp_hex;
        logic       exp_tick;
        logic       exp_wrap;
        logic       exp_dp;
    } vec_t;

    vec_t vecs[$];

    hex_digit_sequencer #(
        .CLK_HZ         (20),
        .STEP_HZ        (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk50MHz  (clk50MHz),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_dir   (btn_dir),
        .load      (load),
        .load_value(load_value),
        .HEX_out   (HEX_out),
        .dp_out    (dp_out),
        .tick      (tick),
        .wrap      (wrap)
    );

    always #5 clk50MHz = ~clk50MHz;

    function automatic logic [31:0] pk(input logic [3:0] h, input logic t, input logic w,
                                       input logic d);
        return {25'd0, h, t, w, d};
    endfunction

    function automatic logic [31:0] obs();
        return pk(HEX_out, tick, wrap, dp_out);
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk50MHz);
    endtask

    // Observed word is {hex[6:3], tick, wrap, dp}.
    initial begin
        int bad;
        logic [6:0] train;

        rst        = 1'b1;
        btn_run    = 1'b0;
        btn_dir    = 1'b0;
        load       = 1'b0;
        load_value = 4'h0;

        vecs.push_back('{9, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0});
        for (int h = 2; h < 16; h++) begin
            vecs.push_back('{10, 1'b0, 4'h0, 4'(h), 1'b1, 1'b0, 1'b0});
        end
        vecs.push_back('{10, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{9, 1'b1, 4'h9, 4'h9, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{10, 1'b0, 4'h0, 4'hA, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{9, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0});

        cycles(3);
        check("reset_state", obs(), pk(4'h0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;

        // Free count, wrap, and load against a due step / mid-period.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wait_cyc > 1) cycles(vecs[i].wait_cyc - 1);
            load       = vecs[i].do_load;
            load_value = vecs[i].ld_val;
            cycles(1);
            load = 1'b0;
            check($sformatf("vec%0d", i), obs(),
                  pk(vecs[i].exp_hex, vecs[i].exp_tick, vecs[i].exp_wrap, vecs[i].exp_dp));
        end

        // Direction press whose toggle lands on a step edge.
        cycles(3);
        btn_dir = 1'b1;
        cycles(7);
        check("dir_coincident_step", obs(), pk(4'h1, 1'b1, 1'b0, 1'b0));
        cycles(2);
        btn_dir = 1'b0;
        cycles(8);
        check("down_1_to_0", obs(), pk(4'h0, 1'b1, 1'b0, 1'b0));
        cycles(10);
        check("down_wrap_0_to_F", obs(), pk(4'hF, 1'b1, 1'b1, 1'b0));
        cycles(10);
        check("down_E", obs(), pk(4'hE, 1'b1, 1'b0, 1'b0));
        cycles(10);
        check("down_D", obs(), pk(4'hD, 1'b1, 1'b0, 1'b0));

        // Bouncy run press, then stable: one pause toggle.
        train = 7'b0101101;
        for (int k = 0; k < 7; k++) begin
            btn_run = train[k];
            cycles(1);
        end
        btn_run = 1'b1;
        cycles(6);
        check("pause_not_yet", obs(), pk(4'hC, 1'b0, 1'b0, 1'b0));
        cycles(1);
        check("pause_toggle", obs(), pk(4'hC, 1'b0, 1'b0, 1'b1));
        cycles(3);
        btn_run = 1'b0;
        cycles(3);
        check("paused_state", obs(), pk(4'hC, 1'b0, 1'b0, 1'b1));
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            cycles(1);
            if (tick !== 1'b0 || HEX_out !== 4'hC || dp_out !== 1'b1) bad++;
        end
        check("paused_frozen", 32'(bad), 32'd0);

        load       = 1'b1;
        load_value = 4'h5;
        cycles(1);
        load = 1'b0;
        check("load_while_paused", obs(), pk(4'h5, 1'b0, 1'b0, 1'b1));

        // Resume: first tick 10 clocks after the run toggle.
        btn_run = 1'b1;
        cycles(6);
        check("resume_not_yet", obs(), pk(4'h5, 1'b0, 1'b0, 1'b1));
        cycles(1);
        check("resume_toggle", obs(), pk(4'h5, 1'b0, 1'b0, 1'b0));
        cycles(1);
        btn_run = 1'b0;
        cycles(8);
        check("resume_before_tick", obs(), pk(4'h5, 1'b0, 1'b0, 1'b0));
        cycles(1);
        check("resume_first_tick", obs(), pk(4'h4, 1'b1, 1'b0, 1'b0));

        // Load 7, pause, then async reset between clock edges.
        load       = 1'b1;
        load_value = 4'h7;
        btn_run    = 1'b1;
        cycles(1);
        load = 1'b0;
        cycles(8);
        btn_run = 1'b0;
        cycles(16);
        check("paused_at_7", obs(), pk(4'h7, 1'b0, 1'b0, 1'b1));
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", obs(), pk(4'h0, 1'b0, 1'b0, 1'b0));
        cycles(2);
        rst = 1'b0;
        cycles(9);
        check("post_reset_no_tick", obs(), pk(4'h0, 1'b0, 1'b0, 1'b0));
        cycles(1);
        check("post_reset_tick_up", obs(), pk(4'h1, 1'b1, 1'b0, 1'b0));

        // Long hold with a short glitch: a single toggle only.
        btn_run = 1'b1;
        cycles(7);
        check("hold_toggle", obs(), pk(4'h1, 1'b0, 1'b0, 1'b1));
        bad = 0;
        for (int k = 8; k <= 100; k++) begin
            btn_run = (k == 40 || k == 41) ? 1'b0 : 1'b1;
            cycles(1);
            if (dp_out !== 1'b1 || tick !== 1'b0) bad++;
        end
        check("hold_single_toggle", 32'(bad), 32'd0);
        btn_run = 1'b0;
        cycles(20);
        check("release_no_toggle", obs(), pk(4'h1, 1'b0, 1'b0, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
